decode_stage: RTL and testbench

RV32I instruction decode stage with one registered output slot. It sits directly upstream of the alu and cond blocks inside verycore. It accepts a fetched instruction word and PC over a valid/ready handshake. It registers the decoded fields (register indices, sign-extended immediate, funct3, mod, op class, write-enable, illegal flag) that the execute stage consumes.

---
 rtl/riscv_pkg.sv | 65 ++++++
 rtl/imm_gen.sv | 22 ++
 rtl/decode_stage.sv | 187 ++++++++++++++++++
 tb/tb_decode_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I opcode, op class and immediate format definitions
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        OP_ALU    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_STORE  = 3'd2,
        OP_BRANCH = 3'd3,
        OP_JAL    = 3'd4,
        OP_JALR   = 3'd5,
        OP_LUI    = 3'd6,
        OP_AUIPC  = 3'd7
    } op_class_e;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

    // Decoded fields held in the output slot (pc is kept separately, it follows XLEN)
    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic        mod;
        op_class_e   op;
        logic        use_imm;
        logic        rd_we;
        logic        illegal;
    } dec_bundle_t;

    // Immediate format selected purely by the major opcode; unlisted opcodes carry no immediate
    function automatic imm_fmt_e opcode_fmt(input logic [6:0] opc);
        imm_fmt_e fmt;
        case (opc)
            OPC_OPIMM, OPC_LOAD, OPC_JALR: fmt = FMT_I;
            OPC_STORE:                     fmt = FMT_S;
            OPC_BRANCH:                    fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:            fmt = FMT_U;
            OPC_JAL:                       fmt = FMT_J;
            default:                       fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - RV32I immediate extraction and sign extension by instruction format
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    // Assemble the immediate for the format implied by the opcode, sign bit is always instr[31]
    always_comb begin
        imm = '0;
        case (opcode_fmt(instr[6:0]))
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'b0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with a single registered output slot
module decode_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_funct3,
    output logic            out_mod,
    output logic [2:0]      out_op,
    output logic            out_use_imm,
    output logic            out_rd_we,
    output logic            out_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] dec_imm;
    op_class_e   dec_op;
    logic        dec_use_imm;
    logic        dec_we_raw;
    logic        dec_mod;
    logic        dec_illegal;
    dec_bundle_t dec_bundle;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    dec_bundle_t     bundle_q, bundle_d;
    logic            load;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    imm_gen u_imm_gen (
        .instr (in_instr),
        .imm   (dec_imm)
    );

    // Classify the opcode and flag encodings outside the supported RV32I subset
    always_comb begin
        dec_op      = OP_ALU;
        dec_use_imm = 1'b0;
        dec_we_raw  = 1'b0;
        dec_mod     = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_we_raw = 1'b1;
                dec_mod    = in_instr[30];
                if (!((funct7 == F7_BASE) ||
                      ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
                    dec_illegal = 1'b1;
            end
            OPC_OPIMM: begin
                dec_use_imm = 1'b1;
                dec_we_raw  = 1'b1;
                // Only the shift-right form has an alternate (arithmetic) variant; there is no SUBI
                if (funct3 == 3'b101)
                    dec_mod = in_instr[30];
                if ((funct3 == 3'b001) && (funct7 != F7_BASE))
                    dec_illegal = 1'b1;
                if ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT))
                    dec_illegal = 1'b1;
            end
            OPC_LOAD: begin
                dec_op      = OP_LOAD;
                dec_use_imm = 1'b1;
                dec_we_raw  = 1'b1;
                if ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111))
                    dec_illegal = 1'b1;
            end
            OPC_STORE: begin
                dec_op      = OP_STORE;
                dec_use_imm = 1'b1;
                if (funct3 >= 3'b011)
                    dec_illegal = 1'b1;
            end
            OPC_BRANCH: begin
                dec_op = OP_BRANCH;
                if ((funct3 == 3'b010) || (funct3 == 3'b011))
                    dec_illegal = 1'b1;
            end
            OPC_JAL: begin
                dec_op      = OP_JAL;
                dec_use_imm = 1'b1;
                dec_we_raw  = 1'b1;
            end
            OPC_JALR: begin
                dec_op      = OP_JALR;
                dec_use_imm = 1'b1;
                dec_we_raw  = 1'b1;
                if (funct3 != 3'b000)
                    dec_illegal = 1'b1;
            end
            OPC_LUI: begin
                dec_op      = OP_LUI;
                dec_use_imm = 1'b1;
                dec_we_raw  = 1'b1;
            end
            OPC_AUIPC: begin
                dec_op      = OP_AUIPC;
                dec_use_imm = 1'b1;
                dec_we_raw  = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11)
            dec_illegal = 1'b1;
    end

    // Pack the decoded fields; writes to x0 and from illegal instructions never reach the regfile
    always_comb begin
        dec_bundle         = '0;
        dec_bundle.rs1     = in_instr[19:15];
        dec_bundle.rs2     = in_instr[24:20];
        dec_bundle.rd      = in_instr[11:7];
        dec_bundle.imm     = dec_imm;
        dec_bundle.funct3  = funct3;
        dec_bundle.mod     = dec_mod;
        dec_bundle.op      = dec_op;
        dec_bundle.use_imm = dec_use_imm;
        dec_bundle.rd_we   = dec_we_raw && !dec_illegal && (in_instr[11:7] != 5'd0);
        dec_bundle.illegal = dec_illegal;
    end

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready;

    // Slot update: flush wins over a load, a drained slot keeps its data but drops valid
    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        bundle_d = bundle_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d  = 1'b1;
            pc_d     = in_pc;
            bundle_d = dec_bundle;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output slot register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            pc_q     <= RESET_PC;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_rs1     = bundle_q.rs1;
    assign out_rs2     = bundle_q.rs2;
    assign out_rd      = bundle_q.rd;
    assign out_imm     = bundle_q.imm;
    assign out_funct3  = bundle_q.funct3;
    assign out_mod     = bundle_q.mod;
    assign out_op      = bundle_q.op;
    assign out_use_imm = bundle_q.use_imm;
    assign out_rd_we   = bundle_q.rd_we;
    assign out_illegal = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - table-driven scoreboard bench for decode_stage
module tb_decode_stage;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        mod;
        logic [2:0]  op;
        logic        use_imm;
        logic        rd_we;
        logic        illegal;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [2:0]  out_funct3;
    logic        out_mod;
    logic [2:0]  out_op;
    logic        out_use_imm;
    logic        out_rd_we;
    logic        out_illegal;

    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    vec_t cur_exp;
    vec_t sb_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_imm     (out_imm),
        .out_funct3  (out_funct3),
        .out_mod     (out_mod),
        .out_op      (out_op),
        .out_use_imm (out_use_imm),
        .out_rd_we   (out_rd_we),
        .out_illegal (out_illegal)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] imm, input logic mod,
                                input logic [2:0] op, input logic use_imm, input logic rd_we,
                                input logic illegal);
        vec_t v;
        v.instr = instr; v.pc = '0; v.imm = imm; v.mod = mod; v.op = op;
        v.use_imm = use_imm; v.rd_we = rd_we; v.illegal = illegal;
        return v;
    endfunction

    task automatic cmp_bundle(input vec_t e);
        logic [24:0] got_ctl, exp_ctl;
        got_ctl = {out_rs1, out_rs2, out_rd, out_funct3, out_mod, out_op, out_use_imm, out_rd_we, out_illegal};
        exp_ctl = {e.instr[19:15], e.instr[24:20], e.instr[11:7], e.instr[14:12],
                   e.mod, e.op, e.use_imm, e.rd_we, e.illegal};
        chk($sformatf("ctl[%h]", e.instr), {39'd0, got_ctl}, {39'd0, exp_ctl});
        chk($sformatf("imm[%h]", e.instr), {32'd0, out_imm}, {32'd0, e.imm});
        chk($sformatf("pc[%h]", e.instr), {32'd0, out_pc}, {32'd0, e.pc});
    endtask

    // Scoreboard: pop on consumption, discard on flush of a held slot, push on acceptance
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
                else cmp_bundle(sb_q.pop_front());
            end else if (out_valid && flush && sb_q.size() > 0) begin
                void'(sb_q.pop_front());
            end
            if (in_valid && in_ready && !flush) sb_q.push_back(cur_exp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v, input logic [31:0] pc);
        cur_exp    = v;
        cur_exp.pc = pc;
        in_valid   = 1'b1;
        in_instr   = v.instr;
        in_pc      = pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t a, b, c;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        cur_exp = mk(32'h0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        tbl.push_back(mk(32'h002081B3, 32'h00000000, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0)); // add x3,x1,x2
        tbl.push_back(mk(32'hFFF00293, 32'hFFFFFFFF, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0)); // addi x5,x0,-1
        tbl.push_back(mk(32'hFE208EE3, 32'hFFFFFFFC, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0)); // beq -4
        tbl.push_back(mk(32'h123453B7, 32'h12345000, 1'b0, 3'd6, 1'b1, 1'b1, 1'b0)); // lui
        tbl.push_back(mk(32'h40208133, 32'h00000000, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0)); // sub
        tbl.push_back(mk(32'h4030D093, 32'h00000403, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0)); // srai
        tbl.push_back(mk(32'h40000093, 32'h00000400, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0)); // addi bit30=1
        tbl.push_back(mk(32'h00000000, 32'h00000000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1)); // all zero
        tbl.push_back(mk(32'h022081B3, 32'h00000000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1)); // funct7=1
        tbl.push_back(mk(32'h00000013, 32'h00000000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0)); // nop, rd0
        tbl.push_back(mk(32'h0020A423, 32'h00000008, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0)); // sw
        tbl.push_back(mk(32'h008000EF, 32'h00000008, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0)); // jal +8
        tbl.push_back(mk(32'h00008067, 32'h00000000, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0)); // jalr x0
        tbl.push_back(mk(32'hFFC12203, 32'hFFFFFFFC, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0)); // lw -4
        tbl.push_back(mk(32'hFFFFF517, 32'hFFFFF000, 1'b0, 3'd7, 1'b1, 1'b1, 1'b0)); // auipc
        tbl.push_back(mk(32'h0000B183, 32'h00000000, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1)); // load f3=011
        tbl.push_back(mk(32'h00009067, 32'h00000000, 1'b0, 3'd5, 1'b1, 1'b0, 1'b1)); // jalr f3=001
        tbl.push_back(mk(32'h0020A063, 32'h00000000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1)); // branch f3=010
        tbl.push_back(mk(32'h002081B2, 32'h00000000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1)); // low bits 10
        tbl.push_back(mk(32'h40109093, 32'h00000401, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1)); // slli alt
        tbl.push_back(mk(32'h402091B3, 32'h00000000, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1)); // sll alt
        tbl.push_back(mk(32'h00B3F663, 32'h0000000C, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0)); // bgeu +12

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_pc", {32'd0, out_pc}, {32'd0, RST_PC});
        chk("reset_fields", {out_imm, 7'd0, out_rs1, out_rs2, out_rd, out_funct3, out_mod, out_op,
                             out_use_imm, out_rd_we, out_illegal}, 64'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Back-to-back table under continuous out_ready
        out_ready = 1'b1;
        foreach (tbl[i]) begin
            step();
            send(tbl[i], 32'h0000_1000 + 32'(i) * 4);
        end
        step();
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("drain_valid", {63'd0, out_valid}, 64'd0);
        chk("drain_imm_hold", {32'd0, out_imm}, {32'd0, tbl[tbl.size()-1].imm});

        // Backpressure: three stall cycles, then A drains as B loads on the same edge
        a = tbl[3]; b = tbl[4]; c = tbl[1];
        step(); send(a, 32'h2000);
        step(); out_ready = 1'b0; send(b, 32'h2004);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_in_ready_%0d", k), {63'd0, in_ready}, 64'd0);
            chk($sformatf("bp_hold_%0d", k), {out_valid, 31'd0, out_imm}, {1'b1, 31'd0, a.imm});
            chk($sformatf("bp_pc_%0d", k), {32'd0, out_pc}, 64'h2000);
            step();
        end
        out_ready = 1'b1;
        step(); send(c, 32'h2008);
        @(negedge clk);
        chk("bp_no_bubble", {63'd0, out_valid}, 64'd1);
        step(); in_valid = 1'b0;
        step();

        // Flush coincident with an acceptable instruction drops it
        step(); send(tbl[0], 32'h3000); flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        step(); flush = 1'b0; send(tbl[2], 32'h3004);
        @(negedge clk);
        chk("flush_drop", {63'd0, out_valid}, 64'd0);
        step(); in_valid = 1'b0;
        step();

        // Flush of a held bundle under backpressure
        send(tbl[5], 32'h3100);
        step(); in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        step(); flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_held", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset while a bundle is held
        step(); send(tbl[6], 32'h4000);
        step(); out_ready = 1'b0; send(tbl[7], 32'h4004);
        @(posedge clk); #3;
        mon_en = 1'b0;
        sb_q.delete();
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_pc", {32'd0, out_pc}, {32'd0, RST_PC});
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        out_ready = 1'b1;
        step(); send(tbl[0], 32'h5000);
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
        step(); step();

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
